// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: state encodings
// and the default operand width.
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        SA_IDLE   = 2'd0,
        SA_SHIFT  = 2'd1,
        SA_FINISH = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell; the only arithmetic in the serial adder.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cIn,
    output logic s,
    output logic cOut
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign s     = w_axb ^ cIn;
    assign cOut  = (a & b) | (cIn & w_axb);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one operand bit pair per clock through a single
// FullAdder, LSB first, with registered result and status flags.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic             OVERFLOW,
    output logic             ZERO
);

    localparam int CW = $clog2(WIDTH);

    sa_state_e        r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-2:0] r_sum_sr;
    logic             r_carry;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum_shift;

    FullAdder u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cIn  (r_carry),
        .s    (w_s),
        .cOut (w_cout)
    );

    // Sum bits enter at the MSB; after WIDTH shifts the LSB has reached bit 0.
    assign w_sum_shift = {w_s, r_sum_sr};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= SA_IDLE;
            r_cnt    <= '0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                SA_IDLE, SA_FINISH: begin
                    r_done <= 1'b0;
                    if (START) begin
                        // Subtraction is A + ~B + 1: invert B and seed carry with SUB.
                        r_a_sr   <= A;
                        r_b_sr   <= SUB ? ~B : B;
                        r_carry  <= SUB;
                        r_cnt    <= '0;
                        r_sum_sr <= '0;
                        r_a_msb  <= A[WIDTH-1];
                        r_b_msb  <= SUB ? ~B[WIDTH-1] : B[WIDTH-1];
                        r_busy   <= 1'b1;
                        r_state  <= SA_SHIFT;
                    end else begin
                        r_state  <= SA_IDLE;
                    end
                end
                SA_SHIFT: begin
                    r_carry  <= w_cout;
                    r_sum_sr <= w_sum_shift[WIDTH-1:1];
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_sum_shift;
                        r_cout   <= w_cout;
                        r_ovf    <= (r_a_msb == r_b_msb) && (w_s != r_a_msb);
                        r_zero   <= (w_sum_shift == '0);
                        r_state  <= SA_FINISH;
                    end
                end
                default: r_state <= SA_IDLE;
            endcase
        end
    end

    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign RESULT   = r_result;
    assign CARRY    = r_cout;
    assign OVERFLOW = r_ovf;
    assign ZERO     = r_zero;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: arithmetic reference model with per-cycle compare,
// plus directed vectors with hand-computed results.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         ovf;
    logic         zero;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .START    (start),
        .SUB      (sub),
        .A        (a),
        .B        (b),
        .BUSY     (busy),
        .DONE     (done),
        .RESULT   (result),
        .CARRY    (carry),
        .OVERFLOW (ovf),
        .ZERO     (zero)
    );

    // Reference arithmetic: returns {carry, overflow, zero, result}.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        longint ux, uy, sx, sy, r, sr, lim;
        logic c, v;
        logic [W-1:0] res;
        ux  = longint'(x);
        uy  = longint'(y);
        lim = longint'(1) << W;
        sx  = x[W-1] ? ux - lim : ux;
        sy  = y[W-1] ? uy - lim : uy;
        if (s) begin
            r  = ux - uy;
            c  = (ux >= uy);
            sr = sx - sy;
        end else begin
            r  = ux + uy;
            c  = (r >= lim);
            sr = sx + sy;
        end
        res = r[W-1:0];
        v   = (sr > (lim / 2) - 1) || (sr < -(lim / 2));
        return {c, v, (res == '0), res};
    endfunction

    // Timing model: an accepted op is busy for W cycles, then DONE for one.
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_res, p_res;
    logic         m_c, m_ov, m_z, p_c, p_ov, p_z;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_c    <= 1'b0;
            m_ov   <= 1'b0;
            m_z    <= 1'b0;
            p_res  <= '0;
            p_c    <= 1'b0;
            p_ov   <= 1'b0;
            p_z    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    m_left <= W;
                    {p_c, p_ov, p_z, p_res} <= model(a, b, sub);
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_res  <= p_res;
                    m_c    <= p_c;
                    m_ov   <= p_ov;
                    m_z    <= p_z;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        chk("cycle", 32'({busy, done, result, carry, ovf, zero}),
            32'({(m_left != 0), m_done, m_res, m_c, m_ov, m_z}));
        chk("busy_done_excl", 32'(busy & done), 32'd0);
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        a = x; b = y; sub = s; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input string name);
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({name, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic expect_op(input string name, input logic [W-1:0] r, input logic c,
                             input logic v, input logic z);
        wait_done(name);
        chk({name, "_latency"}, 32'(cyc), 32'd9);
        chk({name, "_result"}, 32'(result), 32'(r));
        chk({name, "_flags"}, 32'({carry, ovf, zero}), 32'({c, v, z}));
    endtask

    initial begin
        int d;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({busy, done, result, carry, ovf, zero}), 32'd0);
        rst = 1'b0;
        tick();

        launch(8'h05, 8'h03, 1'b0); expect_op("add_5_3",   8'h08, 1'b0, 1'b0, 1'b0);
        launch(8'hFF, 8'h01, 1'b0); expect_op("add_ff_1",  8'h00, 1'b1, 1'b0, 1'b1);
        launch(8'h7F, 8'h01, 1'b0); expect_op("add_7f_1",  8'h80, 1'b0, 1'b1, 1'b0);
        launch(8'h03, 8'h05, 1'b1); expect_op("sub_3_5",   8'hFE, 1'b0, 1'b0, 1'b0);
        launch(8'h80, 8'h01, 1'b1); expect_op("sub_80_1",  8'h7F, 1'b1, 1'b1, 1'b0);
        launch(8'h00, 8'h80, 1'b1); expect_op("sub_0_80",  8'h80, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();

        // START mid-operation must not disturb the op in flight.
        launch(8'h10, 8'h20, 1'b0);
        tick(); cyc = 2;
        tick(); cyc = 3;
        a = 8'hAA; start = 1'b1;
        tick(); cyc = 4;
        start = 1'b0;
        expect_op("ignore_start", 8'h30, 1'b0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset mid-operation.
        launch(8'h05, 8'h03, 1'b0);
        repeat (4) begin tick(); cyc++; end
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({busy, done, result, carry, ovf, zero}), 32'd0);
        tick();
        rst = 1'b0;
        d = 0;
        repeat (12) begin
            tick();
            if (done) d++;
        end
        chk("no_done_after_reset", 32'(d), 32'd0);
        launch(8'h55, 8'h55, 1'b1); expect_op("sub_55_55", 8'h00, 1'b1, 1'b0, 1'b1);

        // Back-to-back: START held in FINISH.
        launch(8'h20, 8'h11, 1'b0); expect_op("b2b_op1", 8'h31, 1'b0, 1'b0, 1'b0);
        a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy_rise", 32'({busy, done}), 32'b10);
        d = 1;
        while (!done && d < 40) begin
            tick();
            d++;
        end
        chk("b2b_done_seen", 32'(done), 32'd1);
        chk("b2b_spacing", 32'(d), 32'd9);
        chk("b2b_result", 32'(result), 32'h02);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
